// File: rtl/ball_motion_controller.sv
// Ball motion and game sequencing for the 64x64 pong field.
// Holds ball position and direction, serve/point/game-over flow and both
// scores. Collision inputs are evaluated against the current bx/by on a tick.
module ball_motion_controller #(
    parameter int unsigned FIELD_MAX   = 63,
    parameter int unsigned START_X     = 32,
    parameter int unsigned START_Y     = 32,
    parameter int unsigned SERVE_DELAY = 4,
    parameter int unsigned WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [1:0] paddle_collision,
    input  logic       wall_collision,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic       in_play,
    output logic [1:0] point_pulse,
    output logic       game_over
);

    localparam logic [5:0] LP_MAX   = 6'(FIELD_MAX);
    localparam logic [5:0] LP_MID   = 6'((FIELD_MAX + 1) / 2);
    localparam logic [5:0] LP_SX    = 6'(START_X);
    localparam logic [5:0] LP_SY    = 6'(START_Y);
    localparam logic [3:0] LP_DELAY = 4'(SERVE_DELAY);
    localparam logic [2:0] LP_WIN   = 3'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_GAME_OVER
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_bx, r_by, w_bx_nxt, w_by_nxt;
    logic       r_dx, r_dy, w_dx_nxt, w_dy_nxt;
    logic [2:0] r_score1, r_score2, w_score1_nxt, w_score2_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_point_pulse, w_pulse_nxt;
    logic       r_in_play, r_game_over;

    logic       w_dx_new, w_dy_new;
    logic       w_miss_right, w_miss_left, w_win;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : v + 3'd1;
    endfunction

    // Direction after this tick's collisions; a paddle bit only counts when
    // the ball is actually travelling toward that paddle.
    always_comb begin
        w_dy_new = r_dy;
        if (wall_collision) w_dy_new = (r_by < LP_MID);
        w_dx_new = r_dx;
        if (!r_dx && paddle_collision[0])     w_dx_new = 1'b1;
        else if (r_dx && paddle_collision[1]) w_dx_new = 1'b0;
    end

    assign w_miss_right = r_dx && (r_bx == LP_MAX) && !paddle_collision[1];
    assign w_miss_left  = !r_dx && (r_bx == 6'd0) && !paddle_collision[0];
    assign w_win = (r_point_pulse[0] && (r_score1 == LP_WIN)) ||
                   (r_point_pulse[1] && (r_score2 == LP_WIN));

    // Next-state and datapath update for every game phase.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt  = r_state;
        w_bx_nxt     = r_bx;
        w_by_nxt     = r_by;
        w_dx_nxt     = r_dx;
        w_dy_nxt     = r_dy;
        w_score1_nxt = r_score1;
        w_score2_nxt = r_score2;
        w_cnt_nxt    = r_cnt;
        w_pulse_nxt  = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SERVE;
                    w_cnt_nxt   = LP_DELAY;
                end
            end
            S_SERVE: begin
                if (tick) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (w_miss_right || w_miss_left) begin
                        // Score, recentre, and serve toward the player who lost.
                        w_state_nxt = S_POINT;
                        w_bx_nxt    = LP_SX;
                        w_by_nxt    = LP_SY;
                        w_dy_nxt    = 1'b1;
                        w_dx_nxt    = w_miss_right;
                        if (w_miss_right) begin
                            w_score1_nxt = sat_inc(r_score1);
                            w_pulse_nxt  = 2'b01;
                        end else begin
                            w_score2_nxt = sat_inc(r_score2);
                            w_pulse_nxt  = 2'b10;
                        end
                    end else begin
                        w_dx_nxt = w_dx_new;
                        w_dy_nxt = w_dy_new;
                        if (w_dx_new && r_bx != LP_MAX)    w_bx_nxt = r_bx + 6'd1;
                        else if (!w_dx_new && r_bx != 6'd0) w_bx_nxt = r_bx - 6'd1;
                        // At a vertical edge heading out: hold and reflect.
                        if (w_dy_new) begin
                            if (r_by == LP_MAX) w_dy_nxt = 1'b0;
                            else                w_by_nxt = r_by + 6'd1;
                        end else begin
                            if (r_by == 6'd0)   w_dy_nxt = 1'b1;
                            else                w_by_nxt = r_by - 6'd1;
                        end
                    end
                end
            end
            S_POINT: begin
                if (w_win) begin
                    w_state_nxt = S_GAME_OVER;
                end else begin
                    w_state_nxt = S_SERVE;
                    w_cnt_nxt   = LP_DELAY;
                end
            end
            S_GAME_OVER: begin
                if (start) begin
                    w_state_nxt  = S_SERVE;
                    w_cnt_nxt    = LP_DELAY;
                    w_score1_nxt = 3'd0;
                    w_score2_nxt = 3'd0;
                    w_dx_nxt     = 1'b1;
                    w_dy_nxt     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state       <= S_IDLE;
            r_bx          <= LP_SX;
            r_by          <= LP_SY;
            r_dx          <= 1'b1;
            r_dy          <= 1'b1;
            r_score1      <= 3'd0;
            r_score2      <= 3'd0;
            r_cnt         <= 4'd0;
            r_point_pulse <= 2'b00;
            r_in_play     <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bx          <= w_bx_nxt;
            r_by          <= w_by_nxt;
            r_dx          <= w_dx_nxt;
            r_dy          <= w_dy_nxt;
            r_score1      <= w_score1_nxt;
            r_score2      <= w_score2_nxt;
            r_cnt         <= w_cnt_nxt;
            r_point_pulse <= w_pulse_nxt;
            r_in_play     <= (w_state_nxt == S_PLAY);
            r_game_over   <= (w_state_nxt == S_GAME_OVER);
        end
    end

    assign bx          = r_bx;
    assign by          = r_by;
    assign score1      = r_score1;
    assign score2      = r_score2;
    assign in_play     = r_in_play;
    assign point_pulse = r_point_pulse;
    assign game_over   = r_game_over;

endmodule
